path_player: RTL and testbench

Drains a solved maze path from the move stack, oldest move first, and replays it as a coordinate sequence for the display/output side of the rat-in-maze datapath. Sits after the solver: the solver pushes 2-bit moves into the stack, and this block drives the stack's `read` port. It converts each move into an absolute (row, col) position and hands positions downstream over a valid/ready handshake. It reports completion and out-of-bounds moves.

---
 rtl/maze_pkg.sv | 23 ++
 rtl/coord_step.sv | 32 +++
 rtl/path_player.sv | 108 ++++++++++
 tb/tb_path_player.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze move encoding, coordinate width and path player state type
package maze_pkg;

  localparam int MOVE_W      = 2;
  localparam int COORD_W_DEF = 4;

  // Move words as pushed by the solver and popped by the player
  typedef enum logic [MOVE_W-1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPT,
    PRES,
    FIN
  } player_state_e;

endpackage

// File: rtl/coord_step.sv
// rtl/coord_step.sv - applies one move to a (row, col) position with bounds detection
module coord_step
  import maze_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  dir_e               move,
  output logic [COORD_W-1:0] next_row,
  output logic [COORD_W-1:0] next_col,
  output logic               oob
);

  localparam logic [COORD_W-1:0] MAX_C = '1;
  localparam logic [COORD_W-1:0] ONE_C = {{(COORD_W-1){1'b0}}, 1'b1};

  // Step one cell; a move off the grid keeps the coordinate and flags oob
  always_comb begin
    next_row = row;
    next_col = col;
    oob      = 1'b0;
    case (move)
      DIR_RIGHT: if (col == MAX_C) oob = 1'b1; else next_col = col + ONE_C;
      DIR_DOWN:  if (row == MAX_C) oob = 1'b1; else next_row = row + ONE_C;
      DIR_LEFT:  if (col == '0)    oob = 1'b1; else next_col = col - ONE_C;
      DIR_UP:    if (row == '0)    oob = 1'b1; else next_row = row - ONE_C;
      default:   oob = 1'b0;
    endcase
  end

endmodule

// File: rtl/path_player.sv
// rtl/path_player.sv - replays the solved move stack as a handshaked coordinate stream
module path_player
  import maze_pkg::*;
#(
  parameter int WIDTH   = MOVE_W,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               read,
  input  logic [WIDTH-1:0]   pout,
  input  logic               is_empty,
  input  logic               all_read,
  output logic               pos_valid,
  input  logic               pos_ready,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               busy,
  output logic               done,
  output logic               err
);

  player_state_e      state;
  logic               last_q;
  dir_e               move;
  logic [COORD_W-1:0] step_row;
  logic [COORD_W-1:0] step_col;
  logic               step_oob;

  assign move = dir_e'(pout[MOVE_W-1:0]);

  coord_step #(.COORD_W(COORD_W)) u_step (
    .row      (row),
    .col      (col),
    .move     (move),
    .next_row (step_row),
    .next_col (step_col),
    .oob      (step_oob)
  );

  // Replay FSM: one read, one capture and one presentation per stored move
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      read      <= 1'b0;
      pos_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      row       <= '0;
      col       <= '0;
      last_q    <= 1'b0;
    end else begin
      read <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          pos_valid <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            row  <= '0;
            col  <= '0;
            err  <= 1'b0;
            busy <= 1'b1;
            if (is_empty) begin
              state <= FIN;
            end else begin
              state <= REQ;
              read  <= 1'b1;
            end
          end
        end
        REQ: begin
          state <= CAPT;
        end
        CAPT: begin
          row       <= step_row;
          col       <= step_col;
          last_q    <= all_read;
          pos_valid <= 1'b1;
          if (step_oob) err <= 1'b1;
          state     <= PRES;
        end
        PRES: begin
          if (pos_ready) begin
            pos_valid <= 1'b0;
            if (last_q) begin
              state <= FIN;
            end else begin
              state <= REQ;
              read  <= 1'b1;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_player.sv
// tb/tb_path_player.sv - directed scoreboard bench for path_player
module tb_path_player;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pos_ready = 1'b1;
  logic       read, pos_valid, busy, done, err;
  logic [1:0] pout;
  logic       is_empty, all_read;
  logic [3:0] row, col;

  logic [1:0] stk_mem [0:15];
  int         stk_cnt = 0;
  int         stk_rd = 0;
  logic       stk_clr = 1'b0;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q [$];
  logic       exp_err;

  int   done_c, reads, npos, hold_len, first_rd, first_pv;
  logic err_done, err_c1, busy_c1, found;

  always #5 clk = ~clk;

  path_player #(.WIDTH(2), .COORD_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .read      (read),
    .pout      (pout),
    .is_empty  (is_empty),
    .all_read  (all_read),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready),
    .row       (row),
    .col       (col),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Stack model: word appears on pout the cycle after read
  always @(posedge clk or negedge rst) begin
    if (!rst) stk_rd <= 0;
    else if (stk_clr) stk_rd <= 0;
    else if (read) begin
      pout   <= stk_mem[stk_rd];
      stk_rd <= stk_rd + 1;
    end
  end

  assign is_empty = (stk_cnt == 0);
  assign all_read = (stk_rd == stk_cnt);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Fill the stack and push the expected positions into the scoreboard
  task automatic load(input int n, input logic [31:0] mv);
    int r, c, nr, nc;
    logic [1:0] m;
    logic [3:0] r4, c4;
    r = 0;
    c = 0;
    exp_q.delete();
    exp_err = 1'b0;
    stk_cnt = n;
    for (int i = 0; i < n; i++) begin
      m = mv[2*i +: 2];
      stk_mem[i] = m;
      nr = r;
      nc = c;
      case (m)
        2'b00:   nc = c + 1;
        2'b01:   nr = r + 1;
        2'b10:   nc = c - 1;
        default: nr = r - 1;
      endcase
      if (nr < 0 || nr > 15 || nc < 0 || nc > 15) exp_err = 1'b1;
      else begin
        r = nr;
        c = nc;
      end
      r4 = r[3:0];
      c4 = c[3:0];
      exp_q.push_back({r4, c4});
    end
    @(negedge clk);
    stk_clr = 1'b1;
    @(negedge clk);
    stk_clr = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle c counts from the edge that sampled start (c = 1 is the next cycle)
  task automatic run(input string tag, input int hold_idx, input int hold_n, input int restart_idx,
                     output int o_done, output int o_reads, output int o_npos, output int o_hold,
                     output int o_frd, output int o_fpv, output logic o_err, output logic o_err1,
                     output logic o_busy1);
    int c, held, cur_len;
    bit have;
    logic [3:0] pr, pc;
    logic [7:0] e;
    c = 0; held = 0; cur_len = 0; have = 0; pr = 0; pc = 0;
    o_done = -1; o_reads = 0; o_npos = 0; o_hold = 0; o_frd = -1; o_fpv = -1;
    o_err = 1'b0; o_err1 = 1'b1; o_busy1 = 1'b0;
    pos_ready = 1'b1;
    while (c < 200) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (c == 1) begin
        o_err1  = err;
        o_busy1 = busy;
      end
      if (read) begin
        o_reads++;
        if (o_frd < 0) o_frd = c;
      end
      if (done) begin
        o_done = c;
        o_err  = err;
        break;
      end
      if (pos_valid) begin
        if (o_fpv < 0) o_fpv = c;
        if (have) check({tag, "_stable"}, {row, col}, {pr, pc});
        else begin
          have = 1;
          pr = row;
          pc = col;
          cur_len = 0;
        end
        cur_len++;
        if (restart_idx == o_npos) start = 1'b1;
        if (o_npos == hold_idx && held < hold_n) begin
          pos_ready = 1'b0;
          held++;
        end else begin
          pos_ready = 1'b1;
          check({tag, "_pos_avail"}, exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_pos"}, {row, col}, e);
          end
          if (o_npos == hold_idx) o_hold = cur_len;
          o_npos++;
          have = 0;
        end
      end
    end
    pos_ready = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_read", read, 0);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rowcol", {row, col}, 0);
    rst = 1'b1;

    // Path right,right,down,down with ready tied high
    load(4, 32'h50);
    do_start();
    run("pathA", -1, 0, -1, done_c, reads, npos, hold_len, first_rd, first_pv, err_done, err_c1, busy_c1);
    check("pathA_first_read", first_rd, 1);
    check("pathA_first_valid", first_pv, 3);
    check("pathA_busy", busy_c1, 1);
    check("pathA_reads", reads, 4);
    check("pathA_npos", npos, 4);
    check("pathA_done_cycle", done_c, 14);
    check("pathA_err", err_done, 0);
    check("pathA_q_empty", exp_q.size(), 0);
    check("pathA_idle_busy", busy, 0);

    // Same path, downstream stalls 5 cycles on the second position
    load(4, 32'h50);
    do_start();
    run("stall", 1, 5, -1, done_c, reads, npos, hold_len, first_rd, first_pv, err_done, err_c1, busy_c1);
    check("stall_hold_len", hold_len, 6);
    check("stall_reads", reads, 4);
    check("stall_npos", npos, 4);
    check("stall_done_cycle", done_c, 19);

    // Empty stack
    load(0, 32'h0);
    do_start();
    run("empty", -1, 0, -1, done_c, reads, npos, hold_len, first_rd, first_pv, err_done, err_c1, busy_c1);
    check("empty_done_cycle", done_c, 2);
    check("empty_reads", reads, 0);
    check("empty_pos_valid", first_pv, -1);

    // Left from origin: clamped, err sticky through done
    load(2, 32'h2);
    do_start();
    run("left", -1, 0, -1, done_c, reads, npos, hold_len, first_rd, first_pv, err_done, err_c1, busy_c1);
    check("left_err_model", exp_err, 1);
    check("left_err_at_done", err_done, 1);
    check("left_npos", npos, 2);
    check("left_err_idle", err, 1);

    // Next start clears err
    load(1, 32'h0);
    do_start();
    run("clear", -1, 0, -1, done_c, reads, npos, hold_len, first_rd, first_pv, err_done, err_c1, busy_c1);
    check("clear_err_c1", err_c1, 0);
    check("clear_done_cycle", done_c, 5);

    // Start pulsed during PRES is ignored
    load(4, 32'h50);
    do_start();
    run("restart", -1, 0, 1, done_c, reads, npos, hold_len, first_rd, first_pv, err_done, err_c1, busy_c1);
    check("restart_reads", reads, 4);
    check("restart_npos", npos, 4);
    check("restart_done_cycle", done_c, 14);

    // Sixteen right moves: the last one runs off the right edge
    load(16, 32'h0);
    do_start();
    run("edge", -1, 0, -1, done_c, reads, npos, hold_len, first_rd, first_pv, err_done, err_c1, busy_c1);
    check("edge_npos", npos, 16);
    check("edge_reads", reads, 16);
    check("edge_err", err_done, 1);
    check("edge_col", col, 15);
    check("edge_done_cycle", done_c, 50);

    // Asynchronous reset while presenting row 3
    load(4, 32'h15);
    do_start();
    pos_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (pos_valid && row == 4'd3) begin
        pos_ready = 1'b0;
        found = 1'b1;
      end
    end
    check("arst_reach_row3", found, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_read", read, 0);
    check("arst_pos_valid", pos_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_rowcol", {row, col}, 0);
    @(negedge clk);
    rst = 1'b1;
    pos_ready = 1'b1;
    load(1, 32'h0);
    do_start();
    run("after_rst", -1, 0, -1, done_c, reads, npos, hold_len, first_rd, first_pv, err_done, err_c1, busy_c1);
    check("after_rst_npos", npos, 1);
    check("after_rst_done_cycle", done_c, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
